ymat_fetch_ctrl: RTL and testbench

Sequencer owning the Y-matrix SRAM read port. Per request it fetches the row-pointer line for a row, extracts that row's pointer, and issues the two data reads at pointer and pointer+1. It returns both address words and both data lines to the consumer. It sits between the row scheduler (request side) and the single-port Y SRAM, replacing ad-hoc address generation with one handshaked, latency-aware FSM.

---
 rtl/ymat_fetch_pkg.sv | 29 ++
 rtl/ymat_fetch_ctrl_ptr_extract.sv | 26 ++
 rtl/ymat_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_ymat_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ymat_fetch_pkg.sv
// Shared types and defaults for the Y-matrix fetch sequencer.
package ymat_fetch_pkg;

    localparam int unsigned ADDR_W_DEF     = 11;
    localparam int unsigned LINE_W_DEF     = 256;
    localparam int unsigned PTR_W_DEF      = 16;
    localparam int unsigned SLOTS_PER_LINE = 16;
    localparam int unsigned SLOT_W         = $clog2(SLOTS_PER_LINE);

    typedef enum logic [2:0] {
        IDLE,
        PTR_RD,
        PTR_WAIT,
        CALC,
        D1_RD,
        D2_RD,
        DATA_WAIT,
        RESP
    } fetchState_t;

    // Identifies which read a returning SRAM line belongs to.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_PTR,
        TAG_D1,
        TAG_D2
    } rdTag_t;

endpackage

// File: rtl/ymat_fetch_ctrl_ptr_extract.sv
// ymat_ptr_extract: selects one pointer slot from a row-pointer line and
// derives the two data addresses plus the out-of-range flag.
module ymat_ptr_extract
    import ymat_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned PTR_W  = PTR_W_DEF
) (
    input  logic [LINE_W-1:0] line,
    input  logic [SLOT_W-1:0] slot,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic              err
);

    logic [PTR_W-1:0] ptr;

    always_comb begin
        ptr   = line[slot*PTR_W +: PTR_W];
        err   = |ptr[PTR_W-1:ADDR_W];
        addr1 = ptr[ADDR_W-1:0];
        addr2 = addr1 + ADDR_W'(1);
    end

endmodule

// File: rtl/ymat_fetch_ctrl.sv
// ymat_fetch_ctrl: Y-matrix SRAM read sequencer (row-pointer lookup, then two data reads).
// Optional macro YFC_DIRECT_EN: nonzero req_addr1/req_addr2 bypass the pointer lookup.
module ymat_fetch_ctrl
    import ymat_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned LINE_W   = LINE_W_DEF,
    parameter int unsigned PTR_W    = PTR_W_DEF,
    parameter int unsigned SRAM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_row,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic [LINE_W-1:0] sram_rd_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_addr1,
    output logic [ADDR_W-1:0] resp_addr2,
    output logic [LINE_W-1:0] resp_data1,
    output logic [LINE_W-1:0] resp_data2,
    output logic              resp_err,
    output logic              busy
);

    fetchState_t       state;
    rdTag_t            strobeTag;
    rdTag_t            landPipe [SRAM_LAT];
    rdTag_t            landTag;
    logic [LINE_W-1:0] ptrLine;
    logic [SLOT_W-1:0] slotReg;
    logic [ADDR_W-1:0] extAddr1;
    logic [ADDR_W-1:0] extAddr2;
    logic              extErr;

`ifndef YFC_DIRECT_EN
    logic unusedDirect;
    assign unusedDirect = ^{req_addr1, req_addr2};
`endif

    assign req_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);
    // Tag pipeline marks the cycle a strobed read's data is on sram_rd_data;
    // clearing it on reset drops any line still in flight.
    assign landTag   = landPipe[SRAM_LAT-1];

    ymat_ptr_extract #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .PTR_W (PTR_W)
    ) ptrExtract (
        .line (ptrLine),
        .slot (slotReg),
        .addr1(extAddr1),
        .addr2(extAddr2),
        .err  (extErr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            strobeTag    <= TAG_NONE;
            for (int unsigned i = 0; i < SRAM_LAT; i++) landPipe[i] <= TAG_NONE;
            ptrLine      <= '0;
            slotReg      <= '0;
            sram_rd_en   <= 1'b0;
            sram_rd_addr <= '0;
            resp_valid   <= 1'b0;
            resp_addr1   <= '0;
            resp_addr2   <= '0;
            resp_data1   <= '0;
            resp_data2   <= '0;
            resp_err     <= 1'b0;
        end else begin
            sram_rd_en  <= 1'b0;
            strobeTag   <= TAG_NONE;
            landPipe[0] <= strobeTag;
            for (int unsigned i = 1; i < SRAM_LAT; i++) landPipe[i] <= landPipe[i-1];
            if (landTag == TAG_D1) resp_data1 <= sram_rd_data;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        slotReg    <= req_row[SLOT_W-1:0];
                        resp_addr1 <= '0;
                        resp_addr2 <= '0;
                        resp_data1 <= '0;
                        resp_data2 <= '0;
                        resp_err   <= 1'b0;
`ifdef YFC_DIRECT_EN
                        if (req_addr1 != '0 || req_addr2 != '0) begin
                            resp_addr1   <= req_addr1;
                            resp_addr2   <= req_addr2;
                            sram_rd_en   <= 1'b1;
                            sram_rd_addr <= req_addr1;
                            strobeTag    <= TAG_D1;
                            state        <= D1_RD;
                        end else
`endif
                        begin
                            sram_rd_en   <= 1'b1;
                            sram_rd_addr <= req_row >> SLOT_W;
                            strobeTag    <= TAG_PTR;
                            state        <= PTR_RD;
                        end
                    end
                end
                PTR_RD: state <= PTR_WAIT;
                PTR_WAIT: begin
                    if (landTag == TAG_PTR) begin
                        ptrLine <= sram_rd_data;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (extErr) begin
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        resp_addr1   <= extAddr1;
                        resp_addr2   <= extAddr2;
                        sram_rd_en   <= 1'b1;
                        sram_rd_addr <= extAddr1;
                        strobeTag    <= TAG_D1;
                        state        <= D1_RD;
                    end
                end
                D1_RD: begin
                    sram_rd_en   <= 1'b1;
                    sram_rd_addr <= resp_addr2;
                    strobeTag    <= TAG_D2;
                    state        <= D2_RD;
                end
                D2_RD: state <= DATA_WAIT;
                DATA_WAIT: begin
                    if (landTag == TAG_D2) begin
                        resp_data2 <= sram_rd_data;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ymat_fetch_ctrl.sv
// Self-checking bench for ymat_fetch_ctrl: SRAM model with latency, randomized requests
// checked against a pointer-table reference model. Honors YFC_DIRECT_EN if defined.
module tb_ymat_fetch_ctrl;

    localparam int LAT = 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [10:0]  req_row = '0;
    logic [10:0]  req_addr1 = '0;
    logic [10:0]  req_addr2 = '0;
    logic         sram_rd_en;
    logic [10:0]  sram_rd_addr;
    logic [255:0] sram_rd_data;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [10:0]  resp_addr1;
    logic [10:0]  resp_addr2;
    logic [255:0] resp_data1;
    logic [255:0] resp_data2;
    logic         resp_err;
    logic         busy;

    int nCmp = 0;
    int nBad = 0;
    int cyc  = 0;

    logic [255:0] mem [2048];
    logic [255:0] dq  [LAT];

    ymat_fetch_ctrl #(
        .ADDR_W  (11),
        .LINE_W  (256),
        .PTR_W   (16),
        .SRAM_LAT(LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_row     (req_row),
        .req_addr1   (req_addr1),
        .req_addr2   (req_addr2),
        .sram_rd_en  (sram_rd_en),
        .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_addr1  (resp_addr1),
        .resp_addr2  (resp_addr2),
        .resp_data1  (resp_data1),
        .resp_data2  (resp_data2),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    initial forever #5 clock = ~clock;

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // SRAM: data for a strobe is on the bus exactly LAT cycles later; garbage otherwise.
    always @(posedge clock) begin
        cyc   <= cyc + 1;
        dq[0] <= sram_rd_en ? mem[sram_rd_addr] : rand_line();
        for (int i = 1; i < LAT; i++) dq[i] <= dq[i-1];
    end
    assign sram_rd_data = dq[LAT-1];

    function automatic void set_ptr(input logic [10:0] row, input logic [15:0] p);
        logic [255:0] ln;
        ln = mem[row >> 4];
        ln[row[3:0]*16 +: 16] = p;
        mem[row >> 4] = ln;
    endfunction

    task automatic run_req(input string name, input logic [10:0] row, input logic [10:0] a1,
                           input logic [10:0] a2, input int hold);
        logic [255:0] ln, d1, d2;
        logic [534:0] snap;
        logic [10:0]  e1, e2;
        logic         direct, eErr, got;
        int           ptr, t0, rOff, expResp, nS;
        int           eOff[$];
        logic [10:0]  eAddr[$];
        int           sOff[$];
        logic [10:0]  sAddr[$];

        ln  = mem[row >> 4];
        ptr = int'(ln[row[3:0]*16 +: 16]);
        direct = 1'b0;
`ifdef YFC_DIRECT_EN
        direct = (a1 != 0) || (a2 != 0);
`endif
        if (direct) begin
            eErr = 1'b0; e1 = a1; e2 = a2;
            eOff.push_back(1); eAddr.push_back(a1);
            eOff.push_back(2); eAddr.push_back(a2);
            expResp = LAT + 3;
        end else begin
            eErr = (ptr >= 2048);
            e1   = 11'(ptr % 2048);
            e2   = 11'((ptr + 1) % 2048);
            eOff.push_back(1); eAddr.push_back(11'(row / 16));
            if (eErr) expResp = LAT + 3;
            else begin
                eOff.push_back(LAT + 3); eAddr.push_back(e1);
                eOff.push_back(LAT + 4); eAddr.push_back(e2);
                expResp = 2 * LAT + 5;
            end
        end
        d1 = eErr ? '0 : mem[e1];
        d2 = eErr ? '0 : mem[e2];

        @(negedge clock);
        nCmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            nBad++;
            $display("FAIL %s accept_ready: req_ready=%b resp_valid=%b, required 1 0", name, req_ready, resp_valid);
        end
        req_valid = 1'b1; req_row = row; req_addr1 = a1; req_addr2 = a2;
        resp_ready = (hold == 0);
        t0 = cyc; got = 1'b0; rOff = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (sram_rd_en === 1'b1) begin sOff.push_back(cyc - t0); sAddr.push_back(sram_rd_addr); end
            if (resp_valid === 1'b1) begin got = 1'b1; rOff = cyc - t0; end
        end

        nCmp++;
        if (rOff != expResp) begin
            nBad++; $display("FAIL %s resp_cycle: got %0d, required %0d", name, rOff, expResp);
        end
        nCmp++;
        if (sOff.size() != eOff.size()) begin
            nBad++; $display("FAIL %s strobe_count: got %0d, required %0d", name, sOff.size(), eOff.size());
        end
        nS = (sOff.size() < eOff.size()) ? sOff.size() : eOff.size();
        for (int i = 0; i < nS; i++) begin
            nCmp++;
            if (sOff[i] != eOff[i] || sAddr[i] !== eAddr[i]) begin
                nBad++;
                $display("FAIL %s strobe%0d: got cycle %0d addr %0d, required cycle %0d addr %0d",
                         name, i, sOff[i], sAddr[i], eOff[i], eAddr[i]);
            end
        end
        nCmp++;
        if (resp_err !== eErr || busy !== 1'b1 || req_ready !== 1'b0) begin
            nBad++;
            $display("FAIL %s resp_flags: err=%b busy=%b req_ready=%b, required %b 1 0", name, resp_err, busy, req_ready, eErr);
        end
        if (!eErr) begin
            nCmp++;
            if (resp_addr1 !== e1 || resp_addr2 !== e2) begin
                nBad++;
                $display("FAIL %s resp_addr: got %0d/%0d, required %0d/%0d", name, resp_addr1, resp_addr2, e1, e2);
            end
        end
        nCmp++;
        if (resp_data1 !== d1) begin
            nBad++; $display("FAIL %s resp_data1: got %h, required %h", name, resp_data1, d1);
        end
        nCmp++;
        if (resp_data2 !== d2) begin
            nBad++; $display("FAIL %s resp_data2: got %h, required %h", name, resp_data2, d2);
        end

        snap = {resp_addr1, resp_addr2, resp_err, resp_data1, resp_data2};
        for (int h = 1; h < hold; h++) begin
            @(negedge clock);
            nCmp++;
            if (resp_valid !== 1'b1 || sram_rd_en !== 1'b0 || req_ready !== 1'b0 ||
                {resp_addr1, resp_addr2, resp_err, resp_data1, resp_data2} !== snap) begin
                nBad++;
                $display("FAIL %s hold%0d: valid=%b strobe=%b req_ready=%b stable=%b, required 1 0 0 1", name, h,
                         resp_valid, sram_rd_en, req_ready,
                         {resp_addr1, resp_addr2, resp_err, resp_data1, resp_data2} === snap);
            end
        end
        resp_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (3) @(negedge clock);
        nCmp++;
        if ({req_ready, sram_rd_en, busy, resp_valid, resp_err} !== 5'b0) begin
            nBad++;
            $display("FAIL reset_flags: got %b, required 00000", {req_ready, sram_rd_en, busy, resp_valid, resp_err});
        end
        nCmp++;
        if ({sram_rd_addr, resp_addr1, resp_addr2, resp_data1, resp_data2} !== '0) begin
            nBad++; $display("FAIL reset_values: addr/data outputs not 0, required 0");
        end
        reset = 1'b0;
        @(negedge clock);
        nCmp++;
        if ({req_ready, busy} !== 2'b10) begin
            nBad++; $display("FAIL post_reset: req_ready/busy=%b, required 10", {req_ready, busy});
        end
    endtask

    task automatic test_pointer_basic();
        set_ptr(11'd37, 16'h0123);
        run_req("row37", 11'd37, 11'd0, 11'd0, 0);
    endtask

    task automatic test_wrap();
        set_ptr(11'd200, 16'h07FF);
        run_req("wrap", 11'd200, 11'd0, 11'd0, 0);
    endtask

    task automatic test_error();
        set_ptr(11'd300, 16'h0800);
        run_req("err", 11'd300, 11'd0, 11'd0, 0);
    endtask

    task automatic test_backpressure();
        set_ptr(11'd555, 16'h0345);
        run_req("bp", 11'd555, 11'd0, 11'd0, 5);
        set_ptr(11'd556, 16'h0100);
        run_req("after_bp", 11'd556, 11'd0, 11'd0, 0);
    endtask

    task automatic test_reset_mid();
        int  t0;
        logic hit;
        set_ptr(11'd100, 16'h0200);
        @(negedge clock);
        req_valid = 1'b1; req_row = 11'd100; req_addr1 = '0; req_addr2 = '0; resp_ready = 1'b1;
        t0 = cyc; hit = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (cyc - t0 == LAT + 4) hit = 1'b1;
        end
        nCmp++;
        if (sram_rd_en !== 1'b1 || sram_rd_addr !== 11'h201) begin
            nBad++; $display("FAIL rstmid_d2: strobe=%b addr=%0d, required 1 513", sram_rd_en, sram_rd_addr);
        end
        reset = 1'b1;
        @(negedge clock);
        nCmp++;
        if ({req_ready, sram_rd_en, busy, resp_valid, resp_err} !== 5'b0 ||
            {resp_addr1, resp_addr2, resp_data1, resp_data2} !== '0) begin
            nBad++;
            $display("FAIL rstmid_clear: flags=%b data1=%h, required all 0",
                     {req_ready, sram_rd_en, busy, resp_valid, resp_err}, resp_data1);
        end
        reset = 1'b0;
        set_ptr(11'd900, 16'h0404);
        run_req("after_rst", 11'd900, 11'd0, 11'd0, 0);
    endtask

    task automatic test_direct();
        set_ptr(11'd51, 16'h0456);
        run_req("direct", 11'd51, 11'd10, 11'd500, 0);
        run_req("direct_zero", 11'd51, 11'd0, 11'd0, 0);
    endtask

    task automatic test_random();
        logic [10:0] row, a1, a2;
        logic [15:0] p;
        int r;
        for (int n = 0; n < 25; n++) begin
            row = 11'($urandom_range(0, 2047));
            r   = int'($urandom_range(0, 9));
            if (r < 2) p = 16'($urandom_range(2048, 65535));
            else if (r == 2) p = 16'h07FF;
            else p = 16'($urandom_range(0, 2047));
            set_ptr(row, p);
            a1 = '0; a2 = '0;
            if ($urandom_range(0, 3) == 0) begin
                a1 = 11'($urandom_range(0, 2047));
                a2 = 11'($urandom_range(0, 2047));
            end
            run_req($sformatf("rand%0d", n), row, a1, a2, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = rand_line();
        test_reset();
        test_pointer_basic();
        test_wrap();
        test_error();
        test_backpressure();
        test_reset_mid();
        test_direct();
        test_random();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
